// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and the access-size decode used by both the datapath and the controller.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Undefined encodings fall back to a full-word access.
    function automatic lsu_size_e access_size(
        input logic [2:0] f3,
        input logic       is_store
    );
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            unique case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            unique case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication, byte-enable mask, misalignment
// detection, and load-data extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] op_b_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    lsu_size_e   sz;
    lsu_size_e   lsz;
    logic [15:0] lane;
    logic        sext;

    always_comb begin
        sz         = access_size(funct3_i, store_i);
        mask_o     = 4'hF;
        wdata_o    = op_b_i;
        misalign_o = 1'b0;
        unique case (sz)
            SZ_BYTE: begin
                mask_o  = 4'b0001 << off_i;
                wdata_o = {4{op_b_i[7:0]}};
            end
            SZ_HALF: begin
                mask_o     = 4'b0011 << off_i;
                wdata_o    = {2{op_b_i[15:0]}};
                misalign_o = off_i[0];
            end
            default: begin
                mask_o     = 4'hF;
                wdata_o    = op_b_i;
                misalign_o = |off_i;
            end
        endcase
    end

    // Only the low half of the shifted word is ever needed.
    always_comb begin
        lsz       = access_size(ld_funct3_i, 1'b0);
        lane      = 16'(rdata_i >> {ld_off_i, 3'b000});
        sext      = ~ld_funct3_i[2];
        ld_data_o = rdata_i;
        unique case (lsz)
            SZ_BYTE: ld_data_o = {{24{sext & lane[7]}}, lane[7:0]};
            SZ_HALF: ld_data_o = {{16{sext & lane[15]}}, lane[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bus handshake FSM, timeout counter, registered bus
// outputs and load-result register between execute and memory stages.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out_address,
    input  logic [31:0] op_b,
    output logic        request,
    output logic        we_re,
    output logic [31:0] mem_addr,
    output logic [3:0]  mask,
    output logic [31:0] store_data_out,
    input  logic        valid,
    input  logic        data_valid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wrap_load_out,
    output logic        stall,
    output logic        misalign,
    output logic        bus_error
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            request_q, request_d;
    logic            we_re_q, we_re_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      fn_q, fn_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wrap_q, wrap_d;
    logic            misalign_q, misalign_d;
    logic            bus_error_q, bus_error_d;

    logic        op;
    logic        timeout;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_ld_data;

    assign op      = load | store;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Load extraction uses the offset/size latched at request time.
    lsu_align u_align (
        .store_i     (store),
        .funct3_i    (funct3),
        .off_i       (alu_out_address[1:0]),
        .op_b_i      (op_b),
        .ld_funct3_i (fn_q),
        .ld_off_i    (off_q),
        .rdata_i     (mem_rdata),
        .mask_o      (al_mask),
        .wdata_o     (al_wdata),
        .misalign_o  (al_misalign),
        .ld_data_o   (al_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        request_d   = request_q;
        we_re_d     = we_re_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        fn_d        = fn_q;
        off_d       = off_q;
        wrap_d      = wrap_q;
        misalign_d  = 1'b0;
        bus_error_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op) begin
                    if (al_misalign) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        cnt_d     = '0;
                        request_d = 1'b1;
                        we_re_d   = store;
                        addr_d    = {alu_out_address[31:2], 2'b00};
                        mask_d    = al_mask;
                        wdata_d   = al_wdata;
                        fn_d      = funct3;
                        off_d     = alu_out_address[1:0];
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (valid && (we_re_q || data_valid)) begin
                    state_d   = S_DONE;
                    request_d = 1'b0;
                    we_re_d   = 1'b0;
                    if (!we_re_q) begin
                        wrap_d = al_ld_data;
                    end
                end else if (timeout) begin
                    state_d     = S_DONE;
                    request_d   = 1'b0;
                    we_re_d     = 1'b0;
                    bus_error_d = 1'b1;
                end else if (valid) begin
                    state_d   = S_WAIT;
                    request_d = 1'b0;
                    we_re_d   = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (data_valid) begin
                    state_d = S_DONE;
                    wrap_d  = al_ld_data;
                end else if (timeout) begin
                    state_d     = S_DONE;
                    bus_error_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            request_q   <= 1'b0;
            we_re_q     <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            fn_q        <= '0;
            off_q       <= '0;
            wrap_q      <= '0;
            misalign_q  <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            request_q   <= request_d;
            we_re_q     <= we_re_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            fn_q        <= fn_d;
            off_q       <= off_d;
            wrap_q      <= wrap_d;
            misalign_q  <= misalign_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign stall = ((state_q == S_IDLE) && op)
                 || (state_q == S_REQ)
                 || (state_q == S_WAIT);

    assign request        = request_q;
    assign we_re          = we_re_q;
    assign mem_addr       = addr_q;
    assign mask           = mask_q;
    assign store_data_out = wdata_q;
    assign wrap_load_out  = wrap_q;
    assign misalign       = misalign_q;
    assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level reference model
// and a bus responder with randomized accept/data latencies.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] alu_out_address;
    logic [31:0] op_b;
    logic        request;
    logic        we_re;
    logic [31:0] mem_addr;
    logic [3:0]  mask;
    logic [31:0] store_data_out;
    logic        valid;
    logic        data_valid;
    logic [31:0] mem_rdata;
    logic [31:0] wrap_load_out;
    logic        stall;
    logic        misalign;
    logic        bus_error;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_wrap = '0;

    load_store_unit #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .store           (store),
        .funct3          (funct3),
        .alu_out_address (alu_out_address),
        .op_b            (op_b),
        .request         (request),
        .we_re           (we_re),
        .mem_addr        (mem_addr),
        .mask            (mask),
        .store_data_out  (store_data_out),
        .valid           (valid),
        .data_valid      (data_valid),
        .mem_rdata       (mem_rdata),
        .wrap_load_out   (wrap_load_out),
        .stall           (stall),
        .misalign        (misalign),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int nbytes(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_mask(input int nb, input int off);
        int m;
        m = ((1 << nb) - 1) << off;
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] v);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = v[8*(l % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] rd, input int nb);
        longint v;
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(rd[8*(off+i) +: 8]) << (8*i);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*nb-1]) v -= longint'(1) << (8*nb);
        return v[31:0];
    endfunction

    task automatic run_access(input string tag, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] opb, input logic [31:0] rd,
                              input int a, input int d);
        int nb, off, k, kend;
        logic mis, ok, exp_req;
        logic [3:0] em;
        logic [31:0] ed;
        nb   = nbytes(st, f3);
        off  = int'(addr[1:0]);
        mis  = (off % nb) != 0;
        em   = m_mask(nb, off);
        ed   = m_wdata(nb, opb);
        k    = st ? a + 1 : a + 1 + d;
        ok   = (k <= T);
        kend = ok ? k : T;
        load = ld; store = st; funct3 = f3; alu_out_address = addr;
        op_b = opb; mem_rdata = rd; valid = 1'b0; data_valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL %s stall_idle: got %b want 1", tag, stall); end
        if (mis) begin
            @(posedge clk); #1;
            valid = 1'b1; data_valid = 1'b1;
            total++;
            if (misalign !== 1'b1) begin bad++; $display("FAIL %s misalign: got %b want 1", tag, misalign); end
            total++;
            if (request !== 1'b0) begin bad++; $display("FAIL %s mis_req: got %b want 0", tag, request); end
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL %s mis_stall: got %b want 0", tag, stall); end
        end else begin
            for (int c = 1; c <= kend; c++) begin
                @(posedge clk); #1;
                valid      = (c == a + 1);
                data_valid = !st && (c == k);
                exp_req    = (c <= a + 1);
                total++;
                if (request !== exp_req) begin bad++; $display("FAIL %s request c%0d: got %b want %b", tag, c, request, exp_req); end
                total++;
                if (stall !== 1'b1) begin bad++; $display("FAIL %s stall c%0d: got %b want 1", tag, c, stall); end
                if (c == 1) begin
                    total++;
                    if (we_re !== st) begin bad++; $display("FAIL %s we_re: got %b want %b", tag, we_re, st); end
                    total++;
                    if (mem_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, {addr[31:2], 2'b00}); end
                    total++;
                    if (mask !== em) begin bad++; $display("FAIL %s mask: got %h want %h", tag, mask, em); end
                    if (st) begin
                        total++;
                        if (store_data_out !== ed) begin bad++; $display("FAIL %s sdata: got %h want %h", tag, store_data_out, ed); end
                    end
                end
            end
            @(posedge clk); #1;
            valid = 1'b0; data_valid = 1'b0;
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL %s done_stall: got %b want 0", tag, stall); end
            total++;
            if (request !== 1'b0 || we_re !== 1'b0) begin bad++; $display("FAIL %s done_req: got %b%b want 00", tag, request, we_re); end
            total++;
            if (bus_error !== !ok) begin bad++; $display("FAIL %s bus_error: got %b want %b", tag, bus_error, !ok); end
            total++;
            if (misalign !== 1'b0) begin bad++; $display("FAIL %s done_mis: got %b want 0", tag, misalign); end
            if (ld && !st && ok) model_wrap = m_load(f3, off, rd, nb);
            total++;
            if (wrap_load_out !== model_wrap) begin bad++; $display("FAIL %s wrap: got %h want %h", tag, wrap_load_out, model_wrap); end
        end
        @(posedge clk); #1;
        load = 1'b0; store = 1'b0; valid = 1'b0; data_valid = 1'b0;
        total++;
        if (misalign !== 1'b0 || bus_error !== 1'b0) begin bad++; $display("FAIL %s pulse_end: got %b%b want 00", tag, misalign, bus_error); end
        total++;
        if (wrap_load_out !== model_wrap) begin bad++; $display("FAIL %s wrap_hold: got %h want %h", tag, wrap_load_out, model_wrap); end
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = '0;
        alu_out_address = '0; op_b = '0; valid = 1'b0; data_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (request !== 1'b0 || we_re !== 1'b0) begin bad++; $display("FAIL reset req: got %b%b want 00", request, we_re); end
        total++;
        if (mem_addr !== 32'h0 || mask !== 4'h0) begin bad++; $display("FAIL reset addr: got %h/%h want 0/0", mem_addr, mask); end
        total++;
        if (store_data_out !== 32'h0 || wrap_load_out !== 32'h0) begin bad++; $display("FAIL reset data: got %h/%h want 0/0", store_data_out, wrap_load_out); end
        total++;
        if (stall !== 1'b0 || misalign !== 1'b0 || bus_error !== 1'b0) begin bad++; $display("FAIL reset flags: got %b%b%b want 000", stall, misalign, bus_error); end
        rst = 1'b0;
        model_wrap = '0;
    endtask

    task automatic test_store_word;
        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2, 0);
    endtask

    task automatic test_load_byte;
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 2);
        total++;
        if (wrap_load_out !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_value: got %h want ffffff80", wrap_load_out); end
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 2);
        total++;
        if (wrap_load_out !== 32'h0000_0080) begin bad++; $display("FAIL lbu_value: got %h want 00000080", wrap_load_out); end
    endtask

    task automatic test_half;
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0);
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h7FFF_0000, 0, 0);
        total++;
        if (wrap_load_out !== 32'h0000_7FFF) begin bad++; $display("FAIL lh_value: got %h want 00007fff", wrap_load_out); end
    endtask

    task automatic test_misalign;
        run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 32'h1111_2222, 0, 0);
        run_access("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0303, 32'h1234, 32'h0, 0, 0);
        run_access("lhu_mis", 1'b1, 1'b0, 3'b101, 32'h0000_0305, 32'h0, 32'h5555_6666, 0, 0);
    endtask

    task automatic test_timeout;
        run_access("to_ld", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 20, 0);
        run_access("to_st", 1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'h1, 32'h0, 4, 0);
        run_access("edge_st", 1'b0, 1'b1, 3'b010, 32'h0000_0408, 32'h2, 32'h0, 3, 0);
        run_access("edge_ld", 1'b1, 1'b0, 3'b010, 32'h0000_040C, 32'h0, 32'h0BAD_CAFE, 1, 2);
        run_access("late_ld", 1'b1, 1'b0, 3'b010, 32'h0000_0410, 32'h0, 32'h1357_9BDF, 0, 4);
        run_access("after_to", 1'b1, 1'b0, 3'b001, 32'h0000_0412, 32'h0, 32'h8001_0000, 0, 0);
    endtask

    task automatic test_reset_mid;
        load = 1'b1; store = 1'b0; funct3 = 3'b010; alu_out_address = 32'h0000_0500;
        valid = 1'b0; data_valid = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        total++;
        if (request !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL rmid wait: got %b%b want 01", request, stall); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0; data_valid = 1'b1; mem_rdata = 32'h1234_5678;
        model_wrap = '0;
        total++;
        if (request !== 1'b0 || we_re !== 1'b0 || mem_addr !== 32'h0 || mask !== 4'h0) begin
            bad++; $display("FAIL rmid bus: got %b%b %h %h want 00 0 0", request, we_re, mem_addr, mask);
        end
        total++;
        if (wrap_load_out !== 32'h0 || store_data_out !== 32'h0 || misalign !== 1'b0 || bus_error !== 1'b0) begin
            bad++; $display("FAIL rmid regs: got %h %h %b%b want 0 0 00", wrap_load_out, store_data_out, misalign, bus_error);
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        total++;
        if (wrap_load_out !== 32'h0 || request !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rmid ignore: got %h %b%b want 0 00", wrap_load_out, request, stall);
        end
        run_access("rmid_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'hA5A5_5A5A, 1, 1);
    endtask

    task automatic test_stray_bus;
        valid = 1'b1; data_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        valid = 1'b0; data_valid = 1'b0;
        total++;
        if (request !== 1'b0 || stall !== 1'b0 || wrap_load_out !== model_wrap) begin
            bad++; $display("FAIL stray: got %b%b %h want 00 %h", request, stall, wrap_load_out, model_wrap);
        end
    endtask

    task automatic test_both_high;
        run_access("both", 1'b1, 1'b1, 3'b000, 32'h0000_0601, 32'h0000_00C3, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic ld, st;
        logic [2:0] f3;
        logic [31:0] addr;
        int nb, off, r;
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 4);
            ld = (r <= 1) || (r == 4);
            st = (r >= 2);
            f3 = 3'($urandom);
            addr = $urandom;
            nb = nbytes(st, f3);
            if ($urandom_range(0, 3) != 0) begin
                off = $urandom_range(0, 3);
                off = off - (off % nb);
                addr[1:0] = 2'(off);
            end
            run_access("rand", ld, st, f3, addr, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_stray_bus();
        test_both_high();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
